// File: rtl/record_mode.sv
// record_mode: turns live key presses into {octave, note, length} song
// entries, inserting rest entries for the gaps between presses. The buffer
// is read back by index in the same shape as the song ROM.
module record_mode #(
  parameter int KEY_BITS = 7,
  parameter int DEPTH    = 64,
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                tick,
  input  logic                oct_up,
  input  logic                oct_down,
  input  logic [KEY_BITS-1:0] note_key,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_octave,
  output logic [2:0]          rd_note,
  output logic [2:0]          rd_length,
  output logic [IDX_BITS:0]   track,
  output logic                full,
  output logic [KEY_BITS-1:0] note_led,
  output logic [1:0]          octave
);

  // state    | meaning
  // IDLE     | not recording; buffer and track hold the last take
  // WAIT     | recording, no key down; counts gap ticks once armed
  // HOLD     | key latched, counting hold ticks until release
  // REST_WR  | writing the rest entry that precedes the held note
  // NOTE_WR  | writing the note entry after release
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_REST_WR = 3'd3;
  localparam logic [2:0] S_NOTE_WR = 3'd4;

  logic [2:0] state;
  logic       gap_armed;
  logic [2:0] gap_cnt;
  logic [2:0] hold_cnt;
  logic [2:0] key_lat;
  logic [1:0] oct_lat;
  logic       wr_en;
  logic       wr_ok;
  logic [7:0] wr_entry;
  logic [7:0] mem [DEPTH];

  // Lowest-numbered pressed key wins when several are down together.
  function automatic logic [2:0] lowest_key(input logic [KEY_BITS-1:0] k);
    logic [2:0] r;
    r = 3'd0;
    for (int i = KEY_BITS - 1; i >= 0; i--) begin
      if (k[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign full  = (track == (IDX_BITS+1)'(DEPTH));
  assign wr_ok = wr_en && !full;

  // Entry to store this cycle; nothing is written once recording is dropped.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = 8'd0;
    if (en && state == S_REST_WR) begin
      wr_en    = 1'b1;
      wr_entry = {oct_lat, 3'd0, gap_cnt};
    end else if (en && state == S_NOTE_WR) begin
      wr_en    = 1'b1;
      wr_entry = {oct_lat, key_lat + 3'd1, (hold_cnt == 3'd0) ? 3'd1 : hold_cnt};
    end
  end

  // LED shows the latched key for as long as the note is considered held.
  always_comb begin
    note_led = '0;
    if (state == S_HOLD || state == S_REST_WR) note_led = KEY_BITS'(1) << key_lat;
  end

  // Octave register, saturating 0..3; simultaneous up/down cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      octave <= 2'd1;
    end else if (oct_up && !oct_down && octave != 2'd3) begin
      octave <= octave + 2'd1;
    end else if (oct_down && !oct_up && octave != 2'd0) begin
      octave <= octave - 2'd1;
    end
  end

  // Capture FSM, tick counters and track count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      track     <= '0;
      gap_armed <= 1'b0;
      gap_cnt   <= 3'd0;
      hold_cnt  <= 3'd0;
      key_lat   <= 3'd0;
      oct_lat   <= 2'd0;
    end else begin
      if (wr_ok) track <= track + (IDX_BITS+1)'(1);
      if (state != S_IDLE && !en) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (en) begin
              state     <= S_WAIT;
              track     <= '0;
              gap_armed <= 1'b0;
              gap_cnt   <= 3'd0;
            end
          end
          S_WAIT: begin
            if (note_key != '0) begin
              key_lat  <= lowest_key(note_key);
              oct_lat  <= octave;
              hold_cnt <= 3'd0;
              state    <= (gap_armed && gap_cnt != 3'd0) ? S_REST_WR : S_HOLD;
            end else if (tick && gap_armed && gap_cnt != 3'd7) begin
              gap_cnt <= gap_cnt + 3'd1;
            end
          end
          S_REST_WR: state <= S_HOLD;
          S_HOLD: begin
            if (note_key == '0) begin
              state <= S_NOTE_WR;
            end else if (tick && hold_cnt != 3'd7) begin
              hold_cnt <= hold_cnt + 3'd1;
            end
          end
          S_NOTE_WR: begin
            gap_armed <= 1'b1;
            gap_cnt   <= 3'd0;
            state     <= S_WAIT;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Entry buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[track[IDX_BITS-1:0]] <= wr_entry;
  end

  // Registered read port; a same-cycle write to rd_idx returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_octave <= 2'd0;
      rd_note   <= 3'd0;
      rd_length <= 3'd0;
    end else begin
      {rd_octave, rd_note, rd_length} <= mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_record_mode.sv
// Directed bench for record_mode with an expected-entry scoreboard.
module tb_record_mode;
  logic       clk = 1'b0;
  logic       rst, en, tick, oct_up, oct_down;
  logic [6:0] note_key;
  logic [5:0] rd_idx;
  logic [1:0] rd_octave;
  logic [2:0] rd_note, rd_length;
  logic [6:0] track;
  logic       full;
  logic [6:0] note_led;
  logic [1:0] octave;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  record_mode #(.KEY_BITS(7), .DEPTH(64), .IDX_BITS(6)) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .oct_up(oct_up),
    .oct_down(oct_down), .note_key(note_key), .rd_idx(rd_idx),
    .rd_octave(rd_octave), .rd_note(rd_note), .rd_length(rd_length),
    .track(track), .full(full), .note_led(note_led), .octave(octave)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic press(input logic [6:0] mask);
    note_key = mask;
    cyc();
    cyc();
  endtask

  task automatic release_key();
    note_key = 7'd0;
    cyc();
    cyc();
  endtask

  task automatic restart();
    en = 1'b0;
    cyc();
    en = 1'b1;
    cyc();
  endtask

  task automatic readback(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      rd_idx = 6'(i);
      cyc();
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("oct[%0d]", i), 32'(rd_octave), 32'(e[7:6]));
        chk($sformatf("note[%0d]", i), 32'(rd_note), 32'(e[5:3]));
        chk($sformatf("len[%0d]", i), 32'(rd_length), 32'(e[2:0]));
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tick = 1'b0; oct_up = 1'b0; oct_down = 1'b0;
    note_key = 7'd0; rd_idx = 6'd0;
    cyc(); cyc();
    chk("rst_track", 32'(track), 32'd0);
    chk("rst_octave", 32'(octave), 32'd1);
    chk("rst_led", 32'(note_led), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd", 32'({rd_octave, rd_note, rd_length}), 32'd0);
    rst = 1'b0;
    cyc();

    // key 2 held 3 ticks
    en = 1'b1;
    cyc();
    press(7'b0000100);
    chk("led_key2", 32'(note_led), 32'b0000100);
    ticks(3);
    release_key();
    exp_q.push_back({2'd1, 3'd3, 3'd3});
    chk("led_off", 32'(note_led), 32'd0);
    chk("track_1", 32'(track), 32'd1);
    readback(1);

    // note, 4-tick rest, note
    restart();
    press(7'b0000001);
    ticks(1);
    release_key();
    exp_q.push_back({2'd1, 3'd1, 3'd1});
    ticks(4);
    press(7'b1000000);
    exp_q.push_back({2'd1, 3'd0, 3'd4});
    ticks(2);
    release_key();
    exp_q.push_back({2'd1, 3'd7, 3'd2});
    chk("track_3", 32'(track), 32'd3);
    readback(3);

    // octave saturation and zero-tick note
    for (int i = 0; i < 3; i++) begin
      oct_up = 1'b1;
      cyc();
      oct_up = 1'b0;
    end
    chk("oct_sat_hi", 32'(octave), 32'd3);
    press(7'b0000010);
    release_key();
    oct_up = 1'b1; oct_down = 1'b1;
    cyc();
    oct_up = 1'b0; oct_down = 1'b0;
    chk("oct_both", 32'(octave), 32'd3);
    chk("track_4", 32'(track), 32'd4);
    rd_idx = 6'd3;
    cyc();
    chk("oct_entry", 32'({rd_octave, rd_note, rd_length}), 32'({2'd3, 3'd2, 3'd1}));
    oct_down = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    oct_down = 1'b0;
    chk("oct_sat_lo", 32'(octave), 32'd0);
    oct_up = 1'b1;
    cyc();
    oct_up = 1'b0;

    // fill the buffer: 65 back-to-back one-tick notes
    restart();
    for (int i = 0; i < 65; i++) begin
      press(7'(1 << (i % 7)));
      ticks(1);
      release_key();
      if (i < 64) exp_q.push_back({2'd1, 3'((i % 7) + 1), 3'd1});
      if (i == 62) chk("full_63", 32'(full), 32'd0);
      if (i == 63) begin
        chk("full_64", 32'(full), 32'd1);
        chk("track_64", 32'(track), 32'd64);
      end
    end
    chk("track_drop", 32'(track), 32'd64);
    chk("full_hold", 32'(full), 32'd1);
    readback(64);

    // en dropped mid-hold discards the note
    restart();
    press(7'b0000100);
    ticks(1);
    release_key();
    press(7'b0010000);
    ticks(1);
    en = 1'b0;
    cyc();
    chk("abort_track", 32'(track), 32'd1);
    chk("abort_led", 32'(note_led), 32'd0);
    note_key = 7'd0;
    cyc();
    en = 1'b1;
    cyc();
    chk("reen_track", 32'(track), 32'd0);

    // long hold, chord, saturated rest, reset mid-hold
    press(7'b0101000);
    chk("led_chord", 32'(note_led), 32'b0001000);
    ticks(12);
    release_key();
    exp_q.push_back({2'd1, 3'd4, 3'd7});
    ticks(9);
    press(7'b0000001);
    exp_q.push_back({2'd1, 3'd0, 3'd7});
    ticks(1);
    chk("track_2", 32'(track), 32'd2);
    readback(2);
    oct_up = 1'b1;
    cyc();
    oct_up = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_track", 32'(track), 32'd0);
    chk("rst2_octave", 32'(octave), 32'd1);
    chk("rst2_led", 32'(note_led), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/record_mode.md
# record_mode

Record-mode capture engine for the rhythm-game top level. It is the writer counterpart of the play-mode song reader. While enabled, it turns the player's key presses into song entries {octave, note, length}, storing rests between presses. Entries go into an internal buffer that play/replay logic reads back by index, in the same shape the song ROM presents: an entry per index plus a track count.

## Interface
Parameters:
- KEY_BITS, 7, number of note keys; key i maps to note code i+1.
- DEPTH, 64, buffer entries.
- IDX_BITS, 6, log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  record mode active; rising edge starts a new recording.
- tick  in  1  one-cycle beat-subdivision pulse (1/8 beat).
- oct_up  in  1  one-cycle pulse, octave +1.
- oct_down  in  1  one-cycle pulse, octave -1.
- note_key  in  KEY_BITS  live key levels, already debounced.
- rd_idx  in  IDX_BITS  read address.
- rd_octave  out  2  entry octave, registered.
- rd_note  out  3  entry note (0 = rest), registered.
- rd_length  out  3  entry length code 1..7, registered.
- track  out  IDX_BITS+1  number of valid entries, 0..DEPTH.
- full  out  1  track == DEPTH.
- note_led  out  KEY_BITS  one-hot of the latched key while held, else 0.
- octave  out  2  current octave register.

## Operation
- States: IDLE, WAIT, HOLD, REST_WR, NOTE_WR.
- IDLE: en=1 → WAIT, clear track and gap_armed. This happens only on the en rising edge: previous recording persists while en=0.
- WAIT, note_key==0: on tick, if gap_armed, gap_cnt saturating-increments to 7.
- WAIT, note_key!=0 (press):
  - Latch key = lowest set bit index and latch octave.
  - hold_cnt=0.
  - If gap_armed and gap_cnt≥1 → REST_WR, else → HOLD.
- REST_WR: write {octave_latched, 0, gap_cnt}; then → HOLD. The note press is not lost.
- HOLD: on tick, hold_cnt saturating-increments to 7. Key changes while note_key!=0 are ignored. note_key==0 → NOTE_WR.
- NOTE_WR: write {octave_latched, key+1, max(hold_cnt,1)}. Then set gap_armed=1 and gap_cnt=0, and go → WAIT.
- Leading silence before the first note is never recorded (gap_armed=0).
- Write: mem[track] ← entry and track ← track+1, only if track<DEPTH. Otherwise the write is dropped, track holds, and full stays 1. The FSM keeps running.
- Octave register:
  - oct_up saturates at 3 and oct_down saturates at 0.
  - Both asserted in the same cycle: no change.
  - Active in every state.
- en=0 in any non-IDLE state → IDLE next cycle. A note in HOLD or a pending rest is discarded. Stored entries and track are kept.
- Read: rd_* ← mem[rd_idx] each cycle. Index ≥ track returns stale or uninitialised contents; the reader bounds by track.
- Reset:
  - state=IDLE, track=0, octave=1, gap_armed=0.
  - gap_cnt=0, hold_cnt=0.
  - note_led=0, rd_*=0.
  - Buffer contents are undefined.

## Timing
- Press sampled at edge N: the FSM is in HOLD (or REST_WR) after N, and note_led is valid the same edge.
- Rest path: REST_WR occupies one cycle; HOLD begins at N+1, and the rest entry is written and track increments at edge N+1.
- Release sampled at edge M (HOLD→NOTE_WR): the entry is written and track increments at edge M+1, and note_led=0 after M.
- A tick coinciding with the release edge is not counted. A tick coinciding with the press edge is not counted.
- Press during NOTE_WR: sampled in WAIT on the following cycle. Minimum gap between presses is one cycle.
- Read latency: 1 cycle from rd_idx to rd_*. Same-cycle write and read of the same index returns old data.
- full updates on the same edge as track.

## Test plan
- Reset, en=1, press key 2 for 3 ticks, release → track=1, rd_idx=0 gives octave 1, note 3, length 3; note_led=0000100 during hold.
- Press key 0 (1 tick), release, wait 4 ticks idle, press key 6 (2 ticks), release → track=3; entries {1,1,1}, {1,0,4}, {1,7,2}.
- oct_up×3 then press key 1 for 0 ticks → octave saturates at 3, entry {3,2,1}; then oct_up+oct_down same cycle → octave stays 3.
- Record 65 one-tick notes with zero gap (release and re-press without a tick between) → track=64, full=1 from the 64th write, 65th dropped, mem[63] intact.
- Press key 4, drop en during HOLD → no entry written, state IDLE, track unchanged. Re-raise en → track=0.
- Hold a key for 12 ticks → length 7. Press keys 3 and 5 simultaneously → note 4 recorded. Assert rst mid-HOLD → track=0, octave=1, note_led=0 next cycle.
